// File: rtl/ysyx_23060229_axi_clint.sv
// AXI4 timer slave: a free-running 64-bit mtime counter behind an MMIO window.
// The read and write channels are served by independent FSMs.
// Optional macro YSYX_23060229_CLINT_MTIMECMP_EN adds mtimecmp (0x8/0xC) and the mtip output.
module ysyx_23060229_axi_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0001_0000,
  parameter int          DIV       = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  output logic [3:0]  rid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
  ,
  output logic        mtip
`endif
);

  typedef enum logic {R_IDLE, R_DATA} rState_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = strb[i] ? newVal[i*8 +: 8] : oldVal[i*8 +: 8];
    return res;
  endfunction

  // FIXED bursts stay on one address; INCR and WRAP both step by a word.
  function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd4;
  endfunction

  logic [63:0] r_mtime;
  logic [31:0] r_presc;
  logic        w_tick;

  rState_t     r_rState;
  logic        r_arready, r_rvalid;
  logic [31:0] r_raddr;
  logic [3:0]  r_rid;
  logic [7:0]  r_rlen, r_rcnt;
  logic [1:0]  r_rburst;
  logic [63:0] r_snapTime;
  logic [31:0] w_rOff, w_rWord;
  logic        w_rInWin;

  wState_t     r_wState;
  logic        r_awready, r_wready, r_bvalid, r_wDecerr;
  logic [1:0]  r_bresp, r_wburst;
  logic [3:0]  r_bid;
  logic [31:0] r_waddr, w_wOff;
  logic        w_wBeat, w_wHit, w_wrLo, w_wrHi, w_awInWin;

  assign w_tick    = (r_presc == 32'(DIV - 1));
  assign w_wOff    = r_waddr - BASE_ADDR;
  assign w_wBeat   = (r_wState == W_DATA) && wvalid && r_wready;
  assign w_wHit    = w_wBeat && !r_wDecerr;
  assign w_wrLo    = w_wHit && (w_wOff[31:2] == 30'd0);
  assign w_wrHi    = w_wHit && (w_wOff[31:2] == 30'd1);
  assign w_awInWin = (awaddr - BASE_ADDR) < WIN_SIZE;

  // Prescaler and mtime; a write beat to either half replaces that cycle's increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= 32'd0;
      r_mtime <= 64'd0;
    end else begin
      r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
      if (w_wrLo)
        r_mtime[31:0] <= mergeBytes(r_mtime[31:0], wdata, wstrb);
      else if (w_wrHi)
        r_mtime[63:32] <= mergeBytes(r_mtime[63:32], wdata, wstrb);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
    end
  end

`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
  logic [63:0] r_mtimecmp, r_snapCmp;
  logic        r_mtip;

  // Compare register, byte-writable, and the registered timer interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mtimecmp <= '1;
      r_mtip     <= 1'b0;
    end else begin
      if (w_wHit && (w_wOff[31:2] == 30'd2))
        r_mtimecmp[31:0] <= mergeBytes(r_mtimecmp[31:0], wdata, wstrb);
      if (w_wHit && (w_wOff[31:2] == 30'd3))
        r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], wdata, wstrb);
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  // Snapshot of mtimecmp taken with the AR handshake.
  always_ff @(posedge clock) begin
    if (reset) r_snapCmp <= 64'd0;
    else if (r_rState == R_IDLE && arvalid && r_arready) r_snapCmp <= r_mtimecmp;
  end

  assign mtip = r_mtip;
`endif

  // Read FSM: accept AR, snapshot the counters, then stream beats until rlast is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rState   <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_raddr    <= 32'd0;
      r_rid      <= 4'd0;
      r_rlen     <= 8'd0;
      r_rcnt     <= 8'd0;
      r_rburst   <= 2'b00;
      r_snapTime <= 64'd0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (arvalid && r_arready) begin
            r_raddr    <= araddr;
            r_rid      <= arid;
            r_rlen     <= arlen;
            r_rburst   <= arburst;
            r_rcnt     <= 8'd0;
            r_snapTime <= r_mtime;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rState   <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_rcnt == r_rlen) begin
              r_rvalid  <= 1'b0;
              r_arready <= 1'b1;
              r_rState  <= R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 8'd1;
              r_raddr <= nextAddr(r_raddr, r_rburst);
            end
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

  assign w_rOff   = r_raddr - BASE_ADDR;
  assign w_rInWin = w_rOff < WIN_SIZE;

  // Register-map read mux over the snapshot; reserved offsets return zero.
  always_comb begin
    w_rWord = 32'd0;
    case (w_rOff[31:2])
      30'd0: w_rWord = r_snapTime[31:0];
      30'd1: w_rWord = r_snapTime[63:32];
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
      30'd2: w_rWord = r_snapCmp[31:0];
      30'd3: w_rWord = r_snapCmp[63:32];
`endif
      default: w_rWord = 32'd0;
    endcase
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = (r_rvalid && w_rInWin) ? w_rWord : 32'd0;
  assign rresp   = (r_rvalid && !w_rInWin) ? 2'b11 : 2'b00;
  assign rlast   = r_rvalid && (r_rcnt == r_rlen);
  assign rid     = r_rid;

  // Write FSM: accept AW, take W beats until wlast, then hold the B response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wState  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_bid     <= 4'd0;
      r_waddr   <= 32'd0;
      r_wburst  <= 2'b00;
      r_wDecerr <= 1'b0;
    end else begin
      case (r_wState)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (awvalid && r_awready) begin
            r_waddr   <= awaddr;
            r_wburst  <= awburst;
            r_bid     <= awid;
            r_wDecerr <= !w_awInWin;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wState  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wBeat) begin
            r_waddr <= nextAddr(r_waddr, r_wburst);
            if (wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= r_wDecerr ? 2'b11 : 2'b00;
              r_wState <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wState  <= W_IDLE;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign bid     = r_bid;

  logic w_unused;
  assign w_unused = ^{arsize, awsize, awlen, w_wOff[1:0]};

endmodule

// File: tb/tb_ysyx_23060229_axi_clint.sv
// Self-checking bench for ysyx_23060229_axi_clint: a reference model of mtime and the
// register map feeds read/write scoreboards, driven by a vector table plus corner sequences.
module tb_ysyx_23060229_axi_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] WIN  = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        rlast;
  logic [3:0]  rid;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        wlast = 1'b0;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  bid;
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
  logic        mtip;
`endif

  ysyx_23060229_axi_clint #(.BASE_ADDR(BASE), .WIN_SIZE(WIN), .DIV(1)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid)
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
    , .mtip(mtip)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } rBeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bExp_t;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  strb;
    logic [1:0]  expResp;
  } vec_t;

  rBeat_t rExp[$];
  bExp_t  bExp[$];

  int assertions = 0;
  int failures   = 0;

  logic [63:0] mMtime = '0;
  logic [63:0] mCmp   = '1;
  logic        mMtip  = 1'b0;
  logic [31:0] mWaddr = '0;
  logic [1:0]  mWburst = '0;
  logic        mWdec  = 1'b0;
  logic [1:0]  lastRresp = '0;
  logic [1:0]  lastBresp = '0;
  bit          checkMtip = 1'b0;
  int          sinceReset = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mergeModel(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] readModel(input logic [31:0] a, output logic [1:0] resp);
    logic [31:0] off;
    off = a - BASE;
    resp = 2'b00;
    if (off >= WIN) begin
      resp = 2'b11;
      return 32'd0;
    end
    case (off[31:2])
      30'd0: return mMtime[31:0];
      30'd1: return mMtime[63:32];
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
      30'd2: return mCmp[31:0];
      30'd3: return mCmp[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Non-reset clock edges since reset deasserted equals mtime for DIV=1 without writes.
  always @(posedge clock) begin
    if (reset) sinceReset <= 0;
    else sinceReset <= sinceReset + 1;
  end

  // Reference model and scoreboards: at each falling edge compare any completing beat,
  // record handshakes about to be taken, and advance the model to its post-edge state.
  always @(negedge clock) begin : model
    rBeat_t rb;
    bExp_t bb;
    logic [31:0] a, off;
    logic [63:0] nextTime, nextCmp;
    bit wrote;
    if (reset) begin
      mMtime = '0;
      mCmp   = '1;
      mMtip  = 1'b0;
      rExp.delete();
      bExp.delete();
    end else begin
      if (rvalid && rready) begin
        if (rExp.size() == 0) checkOutput("unexpectedRBeat", 1'b1, 1'b0);
        else begin
          rb = rExp.pop_front();
          checkOutput("rdata", rdata, rb.data);
          checkOutput("rresp", rresp, rb.resp);
          checkOutput("rid", rid, rb.id);
          checkOutput("rlast", rlast, rb.last);
          lastRresp = rresp;
        end
      end
      if (bvalid && bready) begin
        if (bExp.size() == 0) checkOutput("unexpectedB", 1'b1, 1'b0);
        else begin
          bb = bExp.pop_front();
          checkOutput("bresp", bresp, bb.resp);
          checkOutput("bid", bid, bb.id);
          lastBresp = bresp;
        end
      end
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
      if (checkMtip) checkOutput("mtip", mtip, mMtip);
`endif
      nextTime = mMtime;
      nextCmp  = mCmp;
      wrote    = 1'b0;
      if (arvalid && arready) begin
        a = araddr;
        for (int i = 0; i <= int'(arlen); i++) begin
          rb.data = readModel(a, rb.resp);
          rb.id   = arid;
          rb.last = (i == int'(arlen));
          rExp.push_back(rb);
          if (arburst != 2'b00) a = a + 32'd4;
        end
      end
      if (wvalid && wready) begin
        if (!mWdec) begin
          off = mWaddr - BASE;
          case (off[31:2])
            30'd0: begin nextTime[31:0]  = mergeModel(mMtime[31:0], wdata, wstrb); wrote = 1'b1; end
            30'd1: begin nextTime[63:32] = mergeModel(mMtime[63:32], wdata, wstrb); wrote = 1'b1; end
`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
            30'd2: nextCmp[31:0]  = mergeModel(mCmp[31:0], wdata, wstrb);
            30'd3: nextCmp[63:32] = mergeModel(mCmp[63:32], wdata, wstrb);
`endif
            default: ;
          endcase
        end
        if (mWburst != 2'b00) mWaddr = mWaddr + 32'd4;
      end
      if (!wrote) nextTime = mMtime + 64'd1;
      if (awvalid && awready) begin
        mWaddr  = awaddr;
        mWburst = awburst;
        mWdec   = (awaddr - BASE) >= WIN;
        bb.resp = mWdec ? 2'b11 : 2'b00;
        bb.id   = awid;
        bExp.push_back(bb);
      end
      mMtip  = (mMtime >= mCmp);
      mMtime = nextTime;
      mCmp   = nextCmp;
    end
  end

  task automatic doRead(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                        input logic [3:0] id);
    bit ok;
    @(posedge clock); #1;
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (arready) begin ok = 1; break; end
    end
    checkOutput("arHandshake", ok, 1'b1);
    @(posedge clock); #1;
    arvalid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rExp.size() == 0) break;
      @(posedge clock); #2;
    end
    checkOutput("rDrain", rExp.size() == 0, 1'b1);
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] strb);
    bit ok;
    @(posedge clock); #1;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (awready) begin ok = 1; break; end
    end
    checkOutput("awHandshake", ok, 1'b1);
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = (b % 2 == 0) ? d0 : d1;
      wstrb = strb;
      wlast = (b == int'(len));
      wvalid = 1'b1;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (wready) begin ok = 1; break; end
      end
      if (!ok) checkOutput("wHandshake", ok, 1'b1);
      @(posedge clock); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bExp.size() == 0) break;
      @(posedge clock); #2;
    end
    checkOutput("bDrain", bExp.size() == 0, 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isWrite) doWrite(v.addr, v.len, v.burst, v.id, v.d0, v.d1, v.strb);
    else doRead(v.addr, v.len, v.burst, v.id);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    localparam int NV = 15;
    vec_t vecs[NV];
    int snapCount;
    bit ok;

    vecs[0]  = '{1'b1, BASE,               8'd1, 2'b01, 4'h3, 32'hFFFF_FFFF, 32'h0, 4'hF, 2'b00};
    vecs[1]  = '{1'b0, BASE,               8'd1, 2'b01, 4'h7, 32'h0, 32'h0, 4'h0, 2'b00};
    vecs[2]  = '{1'b0, 32'h0300_0000,      8'd2, 2'b00, 4'h2, 32'h0, 32'h0, 4'h0, 2'b11};
    vecs[3]  = '{1'b1, 32'h0300_0000,      8'd0, 2'b01, 4'h9, 32'h1234, 32'h0, 4'hF, 2'b11};
    vecs[4]  = '{1'b0, BASE + 32'h4,       8'd0, 2'b00, 4'h1, 32'h0, 32'h0, 4'h0, 2'b00};
    vecs[5]  = '{1'b1, BASE + 32'h10,      8'd0, 2'b01, 4'hC, 32'hAAAA_AAAA, 32'h0, 4'hF, 2'b00};
    vecs[6]  = '{1'b0, BASE + 32'h10,      8'd1, 2'b01, 4'h4, 32'h0, 32'h0, 4'h0, 2'b00};
    vecs[7]  = '{1'b1, BASE + 32'h4,       8'd0, 2'b01, 4'hB, 32'h1234_BEEF, 32'h0, 4'h3, 2'b00};
    vecs[8]  = '{1'b0, BASE,               8'd1, 2'b01, 4'h6, 32'h0, 32'h0, 4'h0, 2'b00};
    vecs[9]  = '{1'b0, BASE,               8'd1, 2'b10, 4'hF, 32'h0, 32'h0, 4'h0, 2'b00};
    vecs[10] = '{1'b1, BASE + 32'hFFFC,    8'd0, 2'b01, 4'h8, 32'h5555_5555, 32'h0, 4'hF, 2'b00};
    vecs[11] = '{1'b0, BASE + WIN,         8'd0, 2'b01, 4'hD, 32'h0, 32'h0, 4'h0, 2'b11};
    vecs[12] = '{1'b0, BASE + 32'hFFFC,    8'd0, 2'b01, 4'hE, 32'h0, 32'h0, 4'h0, 2'b00};
    vecs[13] = '{1'b1, BASE,               8'd1, 2'b00, 4'h5, 32'h5, 32'h10, 4'hF, 2'b00};
    vecs[14] = '{1'b0, BASE - 32'h4,       8'd0, 2'b01, 4'hA, 32'h0, 32'h0, 4'h0, 2'b11};

    // Reset state.
    repeat (3) @(posedge clock);
    #2;
    checkOutput("resetRvalid", rvalid, 1'b0);
    checkOutput("resetBvalid", bvalid, 1'b0);
    checkOutput("resetWready", wready, 1'b0);
    checkOutput("resetRdata", rdata, 32'd0);
    checkOutput("resetRresp", rresp, 2'b00);
    checkOutput("resetBresp", bresp, 2'b00);
    checkOutput("resetRid", rid, 4'd0);
    checkOutput("resetBid", bid, 4'd0);
    checkOutput("resetRlast", rlast, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #2;
    checkOutput("arreadyAfterReset", arready, 1'b1);
    checkOutput("awreadyAfterReset", awready, 1'b1);
    repeat (9) @(posedge clock);

    // Single read: one-cycle latency, data equals elapsed cycles at the AR handshake.
    @(posedge clock); #1;
    araddr = BASE; arlen = 8'd0; arburst = 2'b01; arid = 4'h5; arvalid = 1'b1;
    ok = 0;
    snapCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (arready) begin ok = 1; snapCount = sinceReset; break; end
    end
    checkOutput("singleArHandshake", ok, 1'b1);
    checkOutput("rvalidBeforeAr", rvalid, 1'b0);
    @(posedge clock); #1;
    arvalid = 1'b0;
    @(negedge clock);
    checkOutput("rvalidLatency", rvalid, 1'b1);
    checkOutput("singleRdataCycles", rdata, snapCount);
    checkOutput("singleRlast", rlast, 1'b1);
    checkOutput("singleRid", rid, 4'h5);
    @(posedge clock); #2;
    checkOutput("singleDrain", rExp.size() == 0, 1'b1);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].isWrite) checkOutput($sformatf("vec%0d_bresp", i), lastBresp, vecs[i].expResp);
      else checkOutput($sformatf("vec%0d_rresp", i), lastRresp, vecs[i].expResp);
    end

    // Stalled two-beat read: lo/hi of one snapshot, held stable while rready is low.
    @(posedge clock); #1;
    rready = 1'b0;
    araddr = BASE; arlen = 8'd1; arburst = 2'b01; arid = 4'h8; arvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (arready) begin ok = 1; break; end
    end
    checkOutput("stallArHandshake", ok, 1'b1);
    @(posedge clock); #1;
    arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #2;
      checkOutput("stallRvalid", rvalid, 1'b1);
      checkOutput("stallRlast", rlast, 1'b0);
      if (rExp.size() > 0) checkOutput("stallRdata", rdata, rExp[0].data);
      else checkOutput("stallQueue", rExp.size(), 2);
    end
    rready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rExp.size() == 0) break;
      @(posedge clock); #2;
    end
    checkOutput("stallDrain", rExp.size() == 0, 1'b1);

    // Reset during a four-beat read.
    @(posedge clock); #1;
    araddr = BASE; arlen = 8'd3; arburst = 2'b01; arid = 4'hA; arvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (arready) begin ok = 1; break; end
    end
    checkOutput("abortArHandshake", ok, 1'b1);
    @(posedge clock); #1;
    arvalid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #2;
    checkOutput("abortRvalid", rvalid, 1'b0);
    checkOutput("abortRdata", rdata, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #2;
    checkOutput("abortArready", arready, 1'b1);
    doRead(BASE, 8'd1, 2'b01, 4'h3);

`ifdef YSYX_23060229_CLINT_MTIMECMP_EN
    // Compare register: mtip follows mtime >= mtimecmp one cycle late.
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #2;
    checkOutput("mtipAfterReset", mtip, 1'b0);
    checkMtip = 1'b1;
    doWrite(BASE + 32'h8, 8'd1, 2'b01, 4'h2, 32'd20, 32'd0, 4'hF);
    checkOutput("mtipBelowCmp", mtip, 1'b0);
    for (int c = 0; c < 60; c++) begin
      if (mMtime >= 64'd24) break;
      @(posedge clock); #2;
    end
    checkOutput("mtipAboveCmp", mtip, 1'b1);
    doRead(BASE + 32'h8, 8'd1, 2'b01, 4'h4);
    doWrite(BASE + 32'h8, 8'd1, 2'b01, 4'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    repeat (2) @(posedge clock);
    #2;
    checkOutput("mtipCleared", mtip, 1'b0);
    checkMtip = 1'b0;
`endif

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060229_axi_clint.md
Name: ysyx_23060229_axi_clint

Overview:
- AXI4 slave responder for the core's memory-side AXI4 master port. It shares that port with the main memory slave through the address decoder.
- Holds a free-running 64-bit mtime counter.
- Serves INCR/FIXED read and write bursts with independent read and write FSMs.
- Gives the core a timer and cycle source at a fixed MMIO window.

Parameters:
- BASE_ADDR, 32'h0200_0000, window base address.
- WIN_SIZE, 32'h0001_0000, window size in bytes; accesses outside it return DECERR.
- DIV, 1, mtime increments once every DIV clocks (DIV>=1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- araddr in 32; arvalid in 1; arready out 1; arid in 4; arlen in 8; arsize in 3; arburst in 2.
- rdata out 32; rresp out 2; rvalid out 1; rready in 1; rlast out 1; rid out 4.
- awaddr in 32; awvalid in 1; awready out 1; awid in 4; awlen in 8; awsize in 3; awburst in 2.
- wdata in 32; wstrb in 4; wvalid in 1; wready out 1; wlast in 1.
- bresp out 2; bvalid out 1; bready in 1; bid out 4.
- mtip out 1; present only with the optional feature.

Behaviour:
- Reset: both FSMs go to IDLE; mtime=0; prescaler=0.
  - rvalid=bvalid=wready=0; rdata=0; rresp=bresp=0; rid=bid=0; rlast=0.
  - arready=awready=1 from the first cycle after reset deasserts.
  - Reset asserted mid-burst aborts the burst with no further beats.
- Register map (offset = addr-BASE_ADDR, bits[1:0] ignored): 0x0 mtime[31:0], 0x4 mtime[63:32]. All other in-window offsets read 0 and ignore writes, with resp OKAY.
- Counter:
  - Prescaler counts 0..DIV-1; mtime+=1 when the prescaler equals DIV-1. mtime wraps 2^64-1 -> 0.
  - A write beat to mtime lo/hi overrides the increment in that cycle. Only the addressed half is written, per wstrb byte lane; the other half holds.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch addr, arid, arlen, arburst, beat count=0. Snapshot all 64 bits of mtime (pre-write value if a write lands in the same cycle), so lo/hi in one burst never tear.
  - R_DATA: rvalid=1 starting the cycle after the AR handshake. rdata comes from the snapshot. rid=latched id. rlast=1 when beat count==arlen.
  - On rvalid&rready: beat count+1. Address +4 for INCR or WRAP (WRAP treated as INCR); unchanged for FIXED (2'b00).
  - rlast beat accepted -> R_IDLE; arready rises the next cycle. rvalid and rdata hold stable while rready=0.
  - arsize<2 returns the full word; the master selects lanes.
  - Out-of-window address: rresp=2'b11, rdata=0, for every beat.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On handshake, latch addr, awid, awburst, plus the DECERR flag if out of window.
  - W_DATA: wready=1. Each wvalid&wready beat is a write to the current address (skipped if DECERR), then the address advances as for reads. The beat with wlast=1 moves to W_RESP. Beat count is not checked against awlen.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY or 2'b11. bvalid&bready -> W_IDLE.
- Read and write FSMs run concurrently. No AW/W decoupling: W beats are accepted only after the AW handshake.

Optional Feature:
- Macro: YSYX_23060229_CLINT_MTIMECMP_EN.
- Defined:
  - Adds the 64-bit mtimecmp register at 0x8 (lo) and 0xC (hi), reset to all-ones, writable per wstrb.
  - Adds the mtip port: registered mtip = (mtime >= mtimecmp), updated every cycle, reset 0.
  - Reads of 0x8 and 0xC come from the AR snapshot.
- Undefined: no mtip port; 0x8 and 0xC behave as reserved offsets (read 0, writes ignored).

Test Plan:
- Reset, DIV=1, idle 10 cycles, then single read of 0x0200_0000 (arlen=0) -> rvalid appears 1 cycle after AR; rdata equals the cycle count at the AR handshake; rlast=1; rresp=0; rid echoes arid=4'h5.
- INCR read, arlen=1, addr 0x0200_0000, rready held low 3 cycles -> two beats {lo, hi} of one snapshot; data stable while stalled; rlast only on beat 2.
- Write 0xFFFF_FFFF to lo and 0x0 to hi in one burst (awlen=1, wstrb=4'hF), then read -> after one increment mtime={0x1,0x0}; lo-to-hi carry correct; bresp=0, bid echoes awid.
- Read at 0x0300_0000 (arlen=2, FIXED) -> 3 beats, rresp=2'b11, rdata=0. Write to 0x0300_0000 -> bresp=2'b11; mtime unaffected.
- Assert reset mid-R_DATA (beat 1 of 4) -> rvalid=0 next cycle, arready=1 after deassert, mtime=0.
- With the macro: write mtimecmp=20 -> mtip=0 while mtime<20, mtip=1 from the cycle after mtime reaches 20; writing mtimecmp=all-ones clears mtip.
